// File: rtl/noc_pkg.sv
// Shared NoC definitions: output port indices, header field layout, XY route.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package noc_pkg;

    // Output port indices; bit d of a route one-hot selects output switch d.
    localparam int PORT_N    = 0;
    localparam int PORT_E    = 1;
    localparam int PORT_S    = 2;
    localparam int PORT_W    = 3;
    localparam int PORT_L    = 4;
    localparam int NUM_PORTS = 5;

    // Default width of each destination coordinate field.
    localparam int DEF_COORD_W = 4;

    typedef logic [NUM_PORTS-1:0] route_t;

    // dest_x occupies the top COORD_W bits of the flit; dest_y sits directly below it.
    function automatic int hdr_x_msb(input int data_width);
        return data_width - 1;
    endfunction

    function automatic int hdr_y_msb(input int data_width, input int coord_w);
        return data_width - 1 - coord_w;
    endfunction

    // XY-by-distance routing: resolve the larger offset first, ties favour X.
    // Operands are unsigned coordinates widened to int, so the absolute
    // differences are exact for any coordinate width used here.
    function automatic route_t route_xy(input int dest_x, input int dest_y,
                                        input int pos_x,  input int pos_y);
        int     dx;
        int     dy;
        route_t r;
        dx = (dest_x >= pos_x) ? (dest_x - pos_x) : (pos_x - dest_x);
        dy = (dest_y >= pos_y) ? (dest_y - pos_y) : (pos_y - dest_y);
        r  = '0;
        if (dx == 0 && dy == 0) begin
            r[PORT_L] = 1'b1;
        end else if (dx >= dy) begin
            if (dest_x > pos_x) r[PORT_E] = 1'b1;
            else                r[PORT_W] = 1'b1;
        end else begin
            if (dest_y < pos_y) r[PORT_N] = 1'b1;
            else                r[PORT_S] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous FIFO for flit+route entries; DEPTH need not be a power of two.
// Latency: a pushed entry is visible on head_dat the cycle after the push edge.
// Backpressure: push is ignored when full unless a pop happens the same cycle.
//
// Ports: clk/rst (sync, active-high), push/push_dat write side,
//        pop/head_dat read side, count/full/empty status.
module noc_flit_fifo #(
    parameter  int WIDTH = 293,
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign do_push  = push && (!full || do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/noc_inport_buffer.sv
// NoC router input port: buffers upstream flits, routes XY, requests one output switch.
// Latency: a flit written into an empty buffer is requested on out_valid the next cycle.
// Backpressure: busy_out rises at DEPTH-1 entries to absorb the sender's in-flight flit.
//
// Ports: clk/rst (sync, active-high); in_flit/in_valid from upstream, busy_out back to it;
//        out_flit/out_valid (one-hot N,E,S,W,L) to output switches, out_clear pop pulses;
//        count occupancy, overflow_err sticky drop flag.
module noc_inport_buffer
    import noc_pkg::*;
#(
    parameter  int DATA_WIDTH = 288,
    parameter  int DEPTH      = 4,
    parameter  int COORD_W    = DEF_COORD_W,
    parameter  int POS_X      = 0,
    parameter  int POS_Y      = 0,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  busy_out,
    output logic [DATA_WIDTH-1:0] out_flit,
    output logic [NUM_PORTS-1:0]  out_valid,
    input  logic [NUM_PORTS-1:0]  out_clear,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow_err
);

    localparam int X_MSB   = hdr_x_msb(DATA_WIDTH);
    localparam int Y_MSB   = hdr_y_msb(DATA_WIDTH, COORD_W);
    localparam int ENTRY_W = DATA_WIDTH + NUM_PORTS;

    logic [COORD_W-1:0]    dest_x;
    logic [COORD_W-1:0]    dest_y;
    route_t                in_route;
    logic [ENTRY_W-1:0]    head_dat;
    route_t                head_route;
    logic                  pop;
    logic                  full;
    logic                  empty;

    assign dest_x   = in_flit[X_MSB -: COORD_W];
    assign dest_y   = in_flit[Y_MSB -: COORD_W];
    // Route is resolved on the write side so the read side only needs a compare.
    assign in_route = route_xy(int'(dest_x), int'(dest_y), POS_X, POS_Y);

    assign head_route = head_dat[ENTRY_W-1 -: NUM_PORTS];
    assign pop        = !empty && ((out_clear & head_route) != '0);

    noc_flit_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (in_valid),
        .push_dat ({in_route, in_flit}),
        .pop      (pop),
        .head_dat (head_dat),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign busy_out = (count >= CNT_W'(DEPTH - 1));
    assign out_flit = empty ? '0 : head_dat[DATA_WIDTH-1:0];
    // Dropping the request in the clear cycle keeps the switch from granting
    // the same head twice before the pop lands.
    assign out_valid = (!empty && !pop) ? head_route : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (in_valid && full && !pop) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: doc/noc_inport_buffer.md
Name: noc_inport_buffer

Overview:
- Receive side of one NoC router link; sits between an upstream router's output switch and the five local output switches.
- Captures incoming flits into a small FIFO and computes the XY-by-distance route per flit.
- Presents the head flit with a one-hot request to the selected output switch and pops the head when that switch returns a clear pulse.
- Back-pressures the upstream link with a busy signal.

Parameters:
- DATA_WIDTH, 288, flit width in bits.
- DEPTH, 4, FIFO entries; minimum 2.
- COORD_W, 4, width of each destination coordinate field.
- POS_X, 0, X coordinate of this router.
- POS_Y, 0, Y coordinate of this router.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- in_flit  in  DATA_WIDTH  flit from the upstream output switch.
- in_valid  in  1  in_flit valid this cycle; one flit per cycle.
- busy_out  out  1  drives the upstream switch's busy; high means do not send.
- out_flit  out  DATA_WIDTH  head flit, broadcast to all five output switches.
- out_valid  out  5  one-hot request for the head flit's direction. Bit order: 0 N, 1 E, 2 S, 3 W, 4 Local.
- out_clear  in  5  bit d pulses when output switch d has taken this port's flit.
- count  out  $clog2(DEPTH+1)  current FIFO occupancy.
- overflow_err  out  1  sticky; a flit arrived while the FIFO was full and was not popped that cycle.

Behaviour:
- Reset (rst high at a clk edge): FIFO emptied, pointers 0, count 0, overflow_err 0. This forces out_valid 0, busy_out 0 and out_flit 0. Reset mid-operation discards all buffered flits, with no partial pop.
- Header fields:
  - dest_x = in_flit[DATA_WIDTH-1 -: COORD_W], unsigned.
  - dest_y = in_flit[DATA_WIDTH-1-COORD_W -: COORD_W], unsigned.
- Routing is computed at write time and stored as a 5-bit one-hot alongside the flit:
  - dx = |dest_x-POS_X|, dy = |dest_y-POS_Y|, computed at COORD_W+1 bits.
  - dx==0 and dy==0 gives Local.
  - Else if dx>=dy (ties go to X): East if dest_x>POS_X, else West.
  - Else North if dest_y<POS_Y, else South.
- Write: when in_valid is high and (count<DEPTH or pop this cycle), the flit and its route are written at the next edge.
  - If in_valid is high while full with no pop, the flit is dropped and overflow_err is set.
- busy_out = (count >= DEPTH-1), combinational from registered count. The upstream switch registers its valid one cycle after sampling busy, so one in-flight flit can still arrive; the one-slot margin guarantees no overflow under a compliant sender.
- Presentation:
  - out_flit = head data whenever count>0, else 0.
  - out_valid = (count>0 && (out_clear & head_route)==0) ? head_route : 5'b0, combinational.
  - Masking out_valid during the clear cycle stops the output switch from re-selecting the same head before it pops.
- Pop: at the edge where (out_clear & head_route) != 0 and count>0.
  - The new head is presented in the following cycle, so an output switch takes at most one flit every 2 cycles from one input port.
  - out_clear bits not matching head_route, or asserted while empty, are ignored.
- Simultaneous push and pop: count unchanged, both pointers advance; this is legal when full.
- Pointers wrap modulo DEPTH; DEPTH need not be a power of two.
- Latency: a flit written at edge t is requested on out_valid during cycle t+1 if the FIFO was empty.

Decomposition:
- Shared noc_pkg holds:
  - port index constants (PORT_N=0, PORT_E=1, PORT_S=2, PORT_W=3, PORT_L=4);
  - COORD_W and the header field offsets;
  - the XY route function, returning a 5-bit one-hot.
- One sub-module: noc_flit_fifo, a parameterised synchronous FIFO with push, pop, count, full and empty, storing DATA_WIDTH+5 bits.
- Routing and the handshake logic stay in noc_inport_buffer.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> out_valid=0, busy_out=0, count=0, overflow_err=0. No flit is captured during reset.
- Routing, POS_X=2, POS_Y=2:
  - dest (5,3) -> out_valid=00010.
  - dest (2,0) -> 00001.
  - dest (2,2) -> 10000.
  - dest (0,4), tie -> 01000.
  - dest (3,6) -> 00100.
- Clear handshake: one flit routed East, out_clear=00010 for 2 consecutive cycles -> out_valid drops to 0 in the first clear cycle, count 1->0 at that edge. The second pulse is ignored, with no extra pop.
- Backpressure, DEPTH=4: 4 back-to-back flits, no clears -> busy_out rises when count=3, count reaches 4, overflow_err=0. A 5th flit with no clear -> dropped, count stays 4, overflow_err=1 and stays 1.
- Full push+pop: count=4, in_valid=1 and matching out_clear in the same cycle -> count stays 4, overflow_err unchanged. FIFO order is preserved across a pointer wrap over 10 flits.
- Mismatched clear and reset mid-operation: head routed North, out_clear=00100 -> no pop, out_valid stays 00001. Then rst with count=3 -> count=0 and out_valid=0 next cycle.
